priority_req_encoder: RTL and testbench
=======================================

Name: priority_req_encoder

Overview:
- Parametrised, sequential successor to the combinational 8:3 priority encoder.
- Captures request pulses on N lines into sticky pending bits.
- Presents the highest-priority pending index on a valid/ready output channel and clears each bit as it is consumed.
- Sits between interrupt/event sources and a single downstream servicer that consumes one index per handshake.

Parameters:
- N, 8, number of request lines (2..64).
- W, $clog2(N), width of index output (derived; not overridden by users).
- CW, $clog2(N+1), width of pending count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req_in  input  N  request pulses; any bit high for one cycle sets that pending bit
- out_ready  input  1  downstream accepts out_idx this cycle
- out_valid  output  1  at least one pending bit set
- out_idx  output  W  index of selected pending bit
- pending  output  N  current pending register
- pending_cnt  output  CW  population count of pending

Behaviour:
- Single clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: pending=0, out_valid=0, out_idx=0, pending_cnt=0; round-robin pointer (if enabled) = N-1. req_in is ignored while rst_n=0.
- State is the pending register (plus the pointer with ROUND_ROBIN_EN).
- out_valid, out_idx and pending_cnt are combinational functions of registered state only; there are no combinational paths from req_in or out_ready to any output.
- Latency: req_in bit k high at edge t -> pending[k]=1 after edge t; visible on outputs in cycle t+1.
- Fixed priority (default): MSB highest. out_idx = index of highest set bit of pending. When out_valid=0, out_idx=0.
- Handshake: a transfer occurs on an edge where out_valid && out_ready. The transfer clears pending[out_idx].
  - out_idx and out_valid are stable while out_valid=1 && out_ready=0, unless a new higher-priority request arrives.
  - A higher-priority arrival may change out_idx before acceptance; the downstream consumes whatever out_idx shows in the handshake cycle.
- Update rule: pending_next = (pending & ~clr) | req_in, where clr = one-hot(out_idx) on transfer, else 0.
  - Set wins: a req_in bit equal to the bit being cleared in the same cycle leaves that bit set, so the request is served again.
- Duplicate requests to an already-pending bit merge; no counting per line and no overflow indication.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation clears all pending requests in that cycle regardless of req_in/out_ready.
- pending_cnt ranges 0..N. At N=64, CW=7.

Optional Feature:
- Macro: PRIORITY_REQ_ENCODER_ROUND_ROBIN_EN
- Undefined: fixed MSB-first priority as above; no pointer register.
- Defined: rotating priority.
  - A W-bit pointer ptr records the search start. Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; out_idx = first set bit in that order.
  - On each transfer of index g, ptr <= (g==0) ? N-1 : g-1.
  - Pointer is unchanged when no transfer occurs. Reset ptr = N-1, so the first selection after reset matches fixed priority.
  - Every continuously-requesting line is served within N transfers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req_in=8'hFF, out_ready=1 -> pending=0, out_valid=0, out_idx=0, pending_cnt=0 throughout.
- Single request, backpressure: req_in=8'b0010_0000 one cycle, out_ready=0 -> next cycle out_valid=1, out_idx=5, pending_cnt=1, held 5 cycles. Then out_ready=1 for one cycle -> out_valid=0 next cycle.
- Priority drain: req_in=8'b1100_1000 one cycle, then out_ready=1 -> out_idx sequence 7,6,3 on consecutive cycles. pending_cnt 3,2,1, then 0 with out_valid=0.
- Set-wins collision: pending=8'b1000_0000, out_ready=1, req_in=8'b1000_0000 same cycle -> next cycle pending=8'b1000_0000, out_idx=7, pending_cnt=1.
- Mid-drain reset: pending=8'b0000_0011, one transfer done, then rst_n=0 with req_in=8'b0000_0100 -> after the edge pending=0, out_valid=0. After release, that request is not present.
- Round-robin (macro defined): req_in=8'b1000_0001 every cycle, out_ready=1 -> out_idx alternates 7,0,7,0, never 7 twice in a row. With macro undefined, same stimulus -> out_idx=7 every cycle. Repeat the drain test at N=16 with bits 15 and 0 -> out_idx 15 then 0.

Source files
------------

// File: rtl/priority_req_encoder.sv
// Sticky request capture with a valid/ready index output; each handshake clears the granted bit.
// Define PRIORITY_REQ_ENCODER_ROUND_ROBIN_EN for rotating priority instead of fixed MSB-first.
module priority_req_encoder #(
    parameter  int N  = 8,
    localparam int W  = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_idx,
    output logic [N-1:0]  pending,
    output logic [CW-1:0] pending_cnt
);

    logic [N-1:0]  r_pending;
    logic [N-1:0]  w_clr;
    logic [W-1:0]  w_idx;
    logic          w_valid;
    logic          w_xfer;
    logic [CW-1:0] w_cnt;

    assign w_valid = |r_pending;
    assign w_xfer  = w_valid & out_ready;

`ifdef PRIORITY_REQ_ENCODER_ROUND_ROBIN_EN
    logic [W-1:0] r_ptr;

    // Search downward from the pointer, wrapping from 0 back to N-1.
    always_comb begin
        int   c;
        logic found;
        w_idx = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(r_ptr) - k;
            if (c < 0) c = c + N;
            if (!found && r_pending[W'(c)]) begin
                w_idx = W'(c);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= W'(N - 1);
        end else if (w_xfer) begin
            r_ptr <= (w_idx == '0) ? W'(N - 1) : w_idx - 1'b1;
        end
    end
`else
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (r_pending[k]) w_idx = W'(k);
        end
    end
`endif

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < N; k++) begin
            w_cnt = w_cnt + CW'(r_pending[k]);
        end
    end

    assign w_clr = w_xfer ? (N'(1) << w_idx) : '0;

    // A new request on the bit being granted keeps it set so it is served again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | req_in;
        end
    end

    assign out_valid   = w_valid;
    assign out_idx     = w_idx;
    assign pending     = r_pending;
    assign pending_cnt = w_cnt;

endmodule

// File: tb/tb_priority_req_encoder.sv
// Self-checking bench for priority_req_encoder at N=8 and N=16 against a behavioural model.
// Honours PRIORITY_REQ_ENCODER_ROUND_ROBIN_EN for the expected selection order.
module tb_priority_req_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  req_in;
    logic        out_ready;
    logic        out_valid;
    logic [2:0]  out_idx;
    logic [7:0]  pending;
    logic [3:0]  pending_cnt;

    logic [15:0] req16;
    logic        ready16;
    logic        valid16;
    logic [3:0]  idx16;
    logic [15:0] pend16;
    logic [4:0]  cnt16;

    int checks = 0;
    int errors = 0;

    logic [63:0] mPend;
    int          mPtr;
    logic [63:0] mPend16;
    int          mPtr16;

    priority_req_encoder #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .out_ready(out_ready),
        .out_valid(out_valid), .out_idx(out_idx), .pending(pending), .pending_cnt(pending_cnt)
    );

    priority_req_encoder #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req_in(req16), .out_ready(ready16),
        .out_valid(valid16), .out_idx(idx16), .pending(pend16), .pending_cnt(cnt16)
    );

    // First set line visiting ptr, ptr-1, ... 0, n-1, ...; fixed priority keeps ptr at n-1.
    function automatic int selIdx(input logic [63:0] p, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr - k + n) % n;
            if (p[c]) return c;
        end
        return 0;
    endfunction

    function automatic int popCount(input logic [63:0] p);
        int s;
        s = 0;
        for (int k = 0; k < 64; k++) s = s + int'(p[k]);
        return s;
    endfunction

    // Expected {valid, idx, pending, cnt} for the 8-line instance.
    function automatic logic [15:0] exp8();
        logic v;
        v = (mPend[7:0] != 8'h00);
        return {v, v ? 3'(selIdx(mPend, mPtr, 8)) : 3'd0, mPend[7:0], 4'(popCount(mPend))};
    endfunction

    function automatic logic [25:0] exp16();
        logic v;
        v = (mPend16[15:0] != 16'h0);
        return {v, v ? 4'(selIdx(mPend16, mPtr16, 16)) : 4'd0, mPend16[15:0], 5'(popCount(mPend16))};
    endfunction

    // Advance one clock: update the model with the inputs present at the edge, then settle.
    task automatic tick();
        int g;
        @(posedge clk);
        if (!rst_n) begin
            mPend = '0;   mPtr = 7;
            mPend16 = '0; mPtr16 = 15;
        end else begin
            g = selIdx(mPend, mPtr, 8);
            if (mPend != 0 && out_ready) begin
                mPend[g] = 1'b0;
`ifdef PRIORITY_REQ_ENCODER_ROUND_ROBIN_EN
                mPtr = (g == 0) ? 7 : g - 1;
`endif
            end
            mPend = mPend | {56'd0, req_in};
            g = selIdx(mPend16, mPtr16, 16);
            if (mPend16 != 0 && ready16) begin
                mPend16[g] = 1'b0;
`ifdef PRIORITY_REQ_ENCODER_ROUND_ROBIN_EN
                mPtr16 = (g == 0) ? 15 : g - 1;
`endif
            end
            mPend16 = mPend16 | {48'd0, req16};
        end
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0; req_in = '0; out_ready = 1'b0; req16 = '0; ready16 = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = 8'hFF; out_ready = 1'b1; req16 = 16'hFFFF; ready16 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({out_valid, out_idx, pending, pending_cnt} !== 16'h0) begin
                errors++;
                $display("[TB] FAIL reset8 cycle %0d got %h want 0000", i, {out_valid, out_idx, pending, pending_cnt});
            end
            checks++;
            if ({valid16, idx16, pend16, cnt16} !== 26'h0) begin
                errors++;
                $display("[TB] FAIL reset16 cycle %0d got %h want 0", i, {valid16, idx16, pend16, cnt16});
            end
        end
        rst_n = 1'b1; req_in = '0; out_ready = 1'b0; req16 = '0; ready16 = 1'b0;
    endtask

    task automatic test_backpressure();
        doReset();
        req_in = 8'b0010_0000; out_ready = 1'b0;
        tick();
        req_in = '0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_idx, pending_cnt} !== {1'b1, 3'd5, 4'd1}) begin
                errors++;
                $display("[TB] FAIL hold cycle %0d got v=%b idx=%0d cnt=%0d want v=1 idx=5 cnt=1", i, out_valid, out_idx, pending_cnt);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pending !== 8'h00) begin
            errors++;
            $display("[TB] FAIL accept got v=%b pend=%h want v=0 pend=00", out_valid, pending);
        end
    endtask

    task automatic test_priority_drain();
        int expIdx[3] = '{7, 6, 3};
        doReset();
        req_in = 8'b1100_1000;
        tick();
        req_in = '0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(expIdx[i]) || pending_cnt !== 4'(3 - i)) begin
                errors++;
                $display("[TB] FAIL drain step %0d got idx=%0d cnt=%0d want idx=%0d cnt=%0d", i, out_idx, pending_cnt, expIdx[i], 3 - i);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || pending_cnt !== 4'd0 || out_idx !== 3'd0) begin
            errors++;
            $display("[TB] FAIL drain end got v=%b cnt=%0d idx=%0d want 0/0/0", out_valid, pending_cnt, out_idx);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_set_wins();
        doReset();
        req_in = 8'h80;
        tick();
        out_ready = 1'b1;
        tick();
        req_in = '0; out_ready = 1'b0;
        checks++;
        if (pending !== 8'h80 || out_idx !== 3'd7 || pending_cnt !== 4'd1) begin
            errors++;
            $display("[TB] FAIL setwins got pend=%h idx=%0d cnt=%0d want 80/7/1", pending, out_idx, pending_cnt);
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        req_in = 8'b0000_0011;
        tick();
        req_in = '0; out_ready = 1'b1;
        tick();
        checks++;
        if (pending !== 8'h01) begin
            errors++;
            $display("[TB] FAIL midreset pre got pend=%h want 01", pending);
        end
        rst_n = 1'b0; req_in = 8'b0000_0100;
        tick();
        checks++;
        if (pending !== 8'h00 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset got pend=%h v=%b want 00/0", pending, out_valid);
        end
        rst_n = 1'b1; req_in = '0; out_ready = 1'b0;
        tick();
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset release got pend=%h want 00", pending);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        doReset();
        req_in = 8'b1000_0001; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
`ifdef PRIORITY_REQ_ENCODER_ROUND_ROBIN_EN
            want = (i % 2 == 0) ? 3'd7 : 3'd0;
`else
            want = 3'd7;
`endif
            checks++;
            if (out_valid !== 1'b1 || out_idx !== want) begin
                errors++;
                $display("[TB] FAIL rr step %0d got idx=%0d want %0d", i, out_idx, want);
            end
            tick();
        end
        req_in = '0; out_ready = 1'b0;
    endtask

    task automatic test_n16_drain();
        doReset();
        req16 = 16'h8001;
        tick();
        req16 = '0; ready16 = 1'b1;
        checks++;
        if (valid16 !== 1'b1 || idx16 !== 4'd15 || cnt16 !== 5'd2) begin
            errors++;
            $display("[TB] FAIL n16 first got idx=%0d cnt=%0d want 15/2", idx16, cnt16);
        end
        tick();
        checks++;
        if (valid16 !== 1'b1 || idx16 !== 4'd0 || cnt16 !== 5'd1) begin
            errors++;
            $display("[TB] FAIL n16 second got idx=%0d cnt=%0d want 0/1", idx16, cnt16);
        end
        tick();
        ready16 = 1'b0;
        checks++;
        if (valid16 !== 1'b0 || pend16 !== 16'h0) begin
            errors++;
            $display("[TB] FAIL n16 empty got v=%b pend=%h want 0/0000", valid16, pend16);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 50) != 0);
            req_in    = 8'($urandom) & 8'($urandom) & 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            req16     = 16'($urandom) & 16'($urandom) & 16'($urandom);
            ready16   = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if ({out_valid, out_idx, pending, pending_cnt} !== exp8()) begin
                errors++;
                $display("[TB] FAIL random8 cycle %0d got %h want %h", i, {out_valid, out_idx, pending, pending_cnt}, exp8());
            end
            checks++;
            if ({valid16, idx16, pend16, cnt16} !== exp16()) begin
                errors++;
                $display("[TB] FAIL random16 cycle %0d got %h want %h", i, {valid16, idx16, pend16, cnt16}, exp16());
            end
        end
        rst_n = 1'b1; req_in = '0; out_ready = 1'b0; req16 = '0; ready16 = 1'b0;
    endtask

    initial begin
        mPend = '0; mPtr = 7; mPend16 = '0; mPtr16 = 15;
        rst_n = 1'b0; req_in = '0; out_ready = 1'b0; req16 = '0; ready16 = 1'b0;
        #1;
        test_reset();
        test_backpressure();
        test_priority_drain();
        test_set_wins();
        test_mid_reset();
        test_round_robin();
        test_n16_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
